// File: rtl/l1_dcache.sv
// l1_dcache: parametrised set-associative write-through, write-allocate L1 data cache with
// true per-set LRU replacement, sitting between the CPU load/store unit and the shared L2 bus.
//
// Optional feature macro: L1D_FLUSH_EN adds flush_i (invalidate all lines while idle).
//
// Ports
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   cpu_valid_i/wen_i/...    CPU request; held stable until cpu_ready_o
//   cpu_ready_o, cpu_rdata_o one-cycle completion pulse and load word
//   bus_busy_i               another master owns the L2 bus; suppresses mem_req_o
//   mem_req_o/wen_o/addr_o   L2 request, write flag, block-aligned address
//   mem_wdata_o              full updated line for write-through
//   mem_ready_i/rdata_i      L2 completion and refill line
//   flush_i                  invalidate all lines (L1D_FLUSH_EN only)
module l1_dcache #(
  parameter int unsigned WAYS        = 4,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_valid_i,
  input  logic                     cpu_wen_i,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  input  logic [31:0]              cpu_wdata_i,
  input  logic [3:0]               cpu_be_i,
  output logic                     cpu_ready_o,
  output logic [31:0]              cpu_rdata_o,
  input  logic                     bus_busy_i,
  output logic                     mem_req_o,
  output logic                     mem_wen_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [8*BLOCK_BYTES-1:0] mem_wdata_o,
  input  logic                     mem_ready_i,
  input  logic [8*BLOCK_BYTES-1:0] mem_rdata_i
`ifdef L1D_FLUSH_EN
  ,
  input  logic                     flush_i
`endif
);

  localparam int unsigned OFF    = $clog2(BLOCK_BYTES);
  localparam int unsigned IDX    = $clog2(SETS);
  localparam int unsigned TAG    = ADDR_W - IDX - OFF;
  localparam int unsigned WSEL   = OFF - 2;
  localparam int unsigned AGE_W  = $clog2(WAYS);
  localparam int unsigned LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {StIdle, StRefill, StWrite, StResp} state_e;

  state_e state_q, state_d;

  // Line storage; data and tags carry no reset, validity is tracked separately.
  logic [LINE_W-1:0] data_q  [WAYS][SETS];
  logic [TAG-1:0]    tag_q   [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [AGE_W-1:0]  age_q   [WAYS][SETS];

  // Captured request and working line (also drives mem_wdata_o and the load word).
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        req_be_q, req_be_d;
  logic              req_wen_q, req_wen_d;
  logic [AGE_W-1:0]  way_q, way_d;
  logic [LINE_W-1:0] line_q, line_d;

  logic flush_req;
`ifdef L1D_FLUSH_EN
  assign flush_req = flush_i;
`else
  assign flush_req = 1'b0;
`endif

  logic flush_now;
  assign flush_now = (state_q == StIdle) && flush_req;

  // Address fields.
  logic [TAG-1:0]  cpu_tag, req_tag;
  logic [IDX-1:0]  cpu_set, req_set;
  logic [WSEL-1:0] cpu_word, req_word;

  assign cpu_tag  = cpu_addr_i[ADDR_W-1:IDX+OFF];
  assign cpu_set  = cpu_addr_i[IDX+OFF-1:OFF];
  assign cpu_word = cpu_addr_i[OFF-1:2];
  assign req_tag  = req_addr_q[ADDR_W-1:IDX+OFF];
  assign req_set  = req_addr_q[IDX+OFF-1:OFF];
  assign req_word = req_addr_q[OFF-1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr_i[1:0], req_addr_q[1:0]};

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL-1:0]   word,
                                                   input logic [31:0]       wdata,
                                                   input logic [3:0]        be);
    logic [LINE_W-1:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[32*int'(word) + 8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Lookup on all ways of the addressed set.
  logic              hit;
  logic [AGE_W-1:0]  hit_way;
  logic [LINE_W-1:0] hit_line;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[cpu_set][w] && (tag_q[w][cpu_set] == cpu_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
    hit_line = data_q[hit_way][cpu_set];
  end

  // Victim: lowest-index invalid way, otherwise the oldest way. Descending loops make the
  // lowest matching index win; the invalid scan runs last so it takes priority.
  logic [AGE_W-1:0] victim_way;

  always_comb begin
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[w][cpu_set] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[cpu_set][w]) victim_way = AGE_W'(w);
    end
  end

  logic mem_done;
  assign mem_done = mem_req_o && mem_ready_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!flush_req && cpu_valid_i) begin
          if (!hit)          state_d = StRefill;
          else if (cpu_wen_i) state_d = StWrite;
          else                state_d = StResp;
        end
      end
      StRefill: if (mem_done) state_d = req_wen_q ? StWrite : StResp;
      StWrite:  if (mem_done) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cpu_ready_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_wen_o   = 1'b0;
    unique case (state_q)
      StRefill: mem_req_o = !bus_busy_i;
      StWrite: begin
        mem_req_o = !bus_busy_i;
        mem_wen_o = !bus_busy_i;
      end
      StResp: begin
        cpu_ready_o = 1'b1;
        cpu_rdata_o = line_q[32*int'(req_word) +: 32];
      end
      default: ;
    endcase
  end

  assign mem_addr_o  = {req_tag, req_set, {OFF{1'b0}}};
  assign mem_wdata_o = line_q;

  // Datapath next state: array write port and LRU touch.
  logic              arr_we;
  logic [AGE_W-1:0]  arr_way;
  logic [IDX-1:0]    arr_set;
  logic [TAG-1:0]    arr_tag;
  logic [LINE_W-1:0] arr_line;
  logic              lru_touch;
  logic [AGE_W-1:0]  lru_way;
  logic [IDX-1:0]    lru_set;

  always_comb begin
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    req_wen_d   = req_wen_q;
    way_d       = way_q;
    line_d      = line_q;
    arr_we      = 1'b0;
    arr_way     = way_q;
    arr_set     = req_set;
    arr_tag     = req_tag;
    arr_line    = line_q;
    lru_touch   = 1'b0;
    lru_way     = way_q;
    lru_set     = req_set;
    unique case (state_q)
      StIdle: begin
        if (!flush_req && cpu_valid_i) begin
          req_addr_d  = cpu_addr_i;
          req_wdata_d = cpu_wdata_i;
          req_be_d    = cpu_be_i;
          req_wen_d   = cpu_wen_i;
          if (hit) begin
            way_d     = hit_way;
            line_d    = cpu_wen_i ? merge_word(hit_line, cpu_word, cpu_wdata_i, cpu_be_i)
                                  : hit_line;
            arr_we    = cpu_wen_i;
            arr_way   = hit_way;
            arr_set   = cpu_set;
            arr_tag   = cpu_tag;
            arr_line  = line_d;
            lru_touch = 1'b1;
            lru_way   = hit_way;
            lru_set   = cpu_set;
          end else begin
            way_d = victim_way;
          end
        end
      end
      StRefill: begin
        if (mem_done) begin
          // Store miss merges into the refill line on the same edge it is written.
          line_d    = req_wen_q ? merge_word(mem_rdata_i, req_word, req_wdata_q, req_be_q)
                                : mem_rdata_i;
          arr_we    = 1'b1;
          arr_line  = line_d;
          lru_touch = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_wen_q   <= 1'b0;
      way_q       <= '0;
      line_q      <= '0;
    end else begin
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      req_wen_q   <= req_wen_d;
      way_q       <= way_d;
      line_q      <= line_d;
    end
  end

  // Valid bits and LRU ages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[w][s] <= AGE_W'(w);
      end
    end else if (flush_now) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[w][s] <= AGE_W'(w);
      end
    end else begin
      if (arr_we) valid_q[arr_set][arr_way] <= 1'b1;
      if (lru_touch) begin
        // Touched way becomes youngest; only ways younger than it age by one.
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == lru_way) begin
            age_q[w][lru_set] <= '0;
          end else if (age_q[w][lru_set] < age_q[lru_way][lru_set]) begin
            age_q[w][lru_set] <= age_q[w][lru_set] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (arr_we) begin
      data_q[arr_way][arr_set] <= arr_line;
      tag_q[arr_way][arr_set]  <= arr_tag;
    end
  end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Parametrised set-associative L1 data cache between the CPU load/store unit and the shared L2 bus. Write-through, write-allocate, true per-set LRU replacement, word-granular accesses with byte enables. Generalises the fixed 4-way/8-set/16-byte data cache to configurable ways, sets and block size, and arbitrates for the L2 bus shared with the instruction cache.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- SETS, 8, sets per way; power of two, ≥2
- BLOCK_BYTES, 16, line size in bytes; power of two, 8..64
- ADDR_W, 32, address width

Derived values:
- OFF = log2(BLOCK_BYTES)
- IDX = log2(SETS)
- TAG = ADDR_W-IDX-OFF

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- cpu_valid_i  in  1  request present; address/data held stable until cpu_ready_o
- cpu_wen_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata_i  in  32  store word
- cpu_be_i  in  4  store byte enables
- cpu_ready_o  out  1  one-cycle completion pulse
- cpu_rdata_o  out  32  load word; valid while cpu_ready_o=1
- bus_busy_i  in  1  another master owns the L2 bus
- mem_req_o  out  1  L2 request
- mem_wen_o  out  1  L2 write
- mem_addr_o  out  ADDR_W  block-aligned address (low OFF bits = 0)
- mem_wdata_o  out  8*BLOCK_BYTES  full updated line for writes
- mem_ready_i  in  1  L2 completion; counted only while mem_req_o=1
- mem_rdata_i  in  8*BLOCK_BYTES  refill line, valid with mem_ready_i
- flush_i  in  1  invalidate all lines (only with L1D_FLUSH_EN)

## Operation
- Address split: tag = [ADDR_W-1:IDX+OFF], set = [IDX+OFF-1:OFF], word = [OFF-1:2].
- FSM states: IDLE, REFILL, WRITE, RESP. Reset state is IDLE.
- IDLE:
  - Lookup is combinational on all ways.
  - Load hit -> RESP.
  - Store hit -> WRITE. Byte-enabled bytes are merged into the line at this edge.
  - Miss -> REFILL. Victim is the lowest-index invalid way; if all are valid, the way with age WAYS-1.
- REFILL:
  - mem_req_o=1 and mem_wen_o=0 whenever bus_busy_i=0.
  - On mem_ready_i: write line data, tag and valid bit, then go to WRITE if store, else RESP.
  - The store merge happens on the same edge as the line write.
- WRITE:
  - mem_req_o=1 and mem_wen_o=1 whenever bus_busy_i=0, carrying the merged line.
  - On mem_ready_i -> RESP.
- RESP: cpu_ready_o=1 and cpu_rdata_o = selected word (post-merge for stores), then -> IDLE.
- LRU, per set: each way holds an age of log2(WAYS) bits.
  - Update on every hit and every fill: the touched way gets age 0; ways younger than its old age increment by 1.
  - Reset ages: way i = i.
- bus_busy_i=1 forces mem_req_o=0. A pending mem_ready_i is ignored while mem_req_o=0.

## Timing
- Reset values:
  - Outputs: cpu_ready_o=0, mem_req_o=0, mem_wen_o=0, cpu_rdata_o=0, mem_addr_o=0, mem_wdata_o=0.
  - All valid bits=0; LRU ages as above.
  - Reset asserted mid-transaction aborts it immediately (asynchronous) with no CPU response.
- Load hit: accepted at edge N, cpu_ready_o high in cycle N+1. Latency 2 cycles including the request cycle.
- Store hit: 3 + L2 latency + busy cycles.
- Load miss: 3 + L2 latency.
- Store miss: 4 + two L2 latencies.
- cpu_ready_o is a single-cycle pulse. A new request may be accepted in the cycle after RESP.
- mem_req_o stays high until the edge that samples mem_ready_i=1, then drops the next cycle.
- A request to the same set and tag as the line just refilled hits.

## Configuration
- L1D_FLUSH_EN defined:
  - flush_i is present.
  - flush_i=1 in IDLE clears all valid bits and resets LRU ages at that edge, taking priority over cpu_valid_i. The CPU request is accepted the following cycle.
  - flush_i outside IDLE is ignored.
- Undefined: no flush_i port; lines are invalidated only by reset.

## Test plan
- Defaults, reset, load 0x0000_0040 (miss) -> REFILL with mem_addr_o=0x40; return line word1=0xDEADBEEF; load 0x44 -> cpu_rdata_o=0xDEADBEEF; second load hits with cpu_ready_o at N+1 and no mem_req_o.
- Store 0x44, be=4'b0011, wdata=0x0000_1234 after the fill above -> mem_wen_o=1, line word1 = 0xDEAD1234; a following load returns 0xDEAD1234.
- Five distinct tags mapping to set 0, touching tags A,B,C,D, then A again, then E -> E evicts B; a load of A still hits and a load of B misses.
- bus_busy_i=1 for 6 cycles during REFILL -> mem_req_o=0 throughout; an early mem_ready_i is ignored; completion happens after bus_busy_i drops.
- rst_ni pulsed low during WRITE -> mem_req_o=0 immediately, no cpu_ready_o, and a subsequent load of the same address misses.
- With L1D_FLUSH_EN: fill 0x40, assert flush_i together with cpu_valid_i in IDLE -> lines cleared and the request then misses.
